// File: rtl/paillier_task_scheduler.sv
// paillier_task_scheduler: round-robin load / dispatch / in-order store
// sequencer for the Paillier core array.
module paillier_task_scheduler #(
  parameter int BLOCK_COUNT = 5,
  parameter int CNT_W       = 64,
  parameter int SEL_W       = (BLOCK_COUNT > 1) ? $clog2(BLOCK_COUNT) : 1
) (
  input  logic                   M_AXI_ACLK,
  input  logic                   M_AXI_ARESETN,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [CNT_W-1:0]       task_total,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ld_req,
  output logic [CNT_W-1:0]       ld_idx,
  output logic [SEL_W-1:0]       ld_sel,
  input  logic                   ld_ack,
  output logic [BLOCK_COUNT-1:0] core_start,
  output logic [1:0]             core_mode,
  input  logic [BLOCK_COUNT-1:0] core_done,
  output logic                   st_req,
  output logic [CNT_W-1:0]       st_idx,
  output logic [SEL_W-1:0]       st_sel,
  input  logic                   st_ack,
  output logic [BLOCK_COUNT-1:0] core_release
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;
  typedef enum logic [1:0] {C_FREE, C_LOAD, C_BUSY, C_READY} core_t;

  localparam logic [SEL_W-1:0] LAST = SEL_W'(BLOCK_COUNT - 1);

  state_t                 r_state;
  state_t                 w_state_nxt;
  core_t                  r_core [BLOCK_COUNT];
  logic [1:0]             r_mode;
  logic [CNT_W-1:0]       r_total;
  logic                   r_zero;
  logic [CNT_W-1:0]       r_ld_cnt;
  logic [CNT_W-1:0]       r_st_cnt;
  logic [SEL_W-1:0]       r_ld_ptr;
  logic [SEL_W-1:0]       r_st_ptr;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_err;
  logic                   r_ld_req;
  logic [CNT_W-1:0]       r_ld_idx;
  logic [SEL_W-1:0]       r_ld_sel;
  logic                   r_st_req;
  logic [CNT_W-1:0]       r_st_idx;
  logic [SEL_W-1:0]       r_st_sel;
  logic [BLOCK_COUNT-1:0] r_core_start;
  logic [BLOCK_COUNT-1:0] r_core_rel;

  logic                   w_start_ok;
  logic                   w_ld_fire;
  logic                   w_st_fire;
  logic                   w_ld_issue;
  logic                   w_st_issue;
  logic [SEL_W-1:0]       w_iss_ptr;
  logic [CNT_W-1:0]       w_iss_idx;
  core_t                  w_ld_core;
  core_t                  w_st_core;
  logic                   w_last;
  logic [BLOCK_COUNT-1:0] w_spur;
  logic                   w_busy_nxt;
  logic                   w_done_nxt;
  logic                   w_err_nxt;

  function automatic logic [SEL_W-1:0] f_wrap(input logic [SEL_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_ld_fire  = r_ld_req && ld_ack;
  assign w_st_fire  = r_st_req && st_ack;
  assign w_ld_core  = r_core[r_ld_ptr];
  assign w_st_core  = r_core[r_st_ptr];
  assign w_last     = (r_st_cnt + CNT_W'(1)) == r_total;
  assign w_iss_ptr  = (r_state == S_IDLE) ? '0 : r_ld_ptr;
  assign w_iss_idx  = (r_state == S_IDLE) ? '0 : r_ld_cnt;

  // Issue decisions for the load and store engines
  always_comb begin
    w_ld_issue = 1'b0;
    w_st_issue = 1'b0;
    if (r_state == S_IDLE) begin
      w_ld_issue = start && (task_total != '0);
    end else if (r_state == S_RUN) begin
      w_ld_issue = !r_ld_req && (r_ld_cnt < r_total) &&
                   (w_ld_core == C_FREE);
      w_st_issue = !r_st_req &&
                   ((w_st_core == C_READY) ||
                    ((w_st_core == C_BUSY) && core_done[r_st_ptr]));
    end
  end

  // A done pulse from a core that is not computing is a protocol error
  always_comb begin
    w_spur = '0;
    for (int k = 0; k < BLOCK_COUNT; k++)
      w_spur[k] = core_done[k] && (r_core[k] != C_BUSY);
  end

  // Top FSM state register
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) r_state <= S_IDLE;
    else                r_state <= w_state_nxt;
  end

  // Top FSM next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (start)
                w_state_nxt = (task_total == '0) ? S_FIN : S_RUN;
      S_RUN:  if (w_st_fire && w_last) w_state_nxt = S_FIN;
      S_FIN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Top FSM outputs; an empty job reports done one cycle after FIN
  always_comb begin
    w_busy_nxt = (w_state_nxt != S_IDLE);
    w_done_nxt = ((r_state == S_RUN) && (w_state_nxt == S_FIN)) ||
                 ((r_state == S_FIN) && r_zero);
    w_err_nxt  = (r_err && !w_start_ok) || (|w_spur);
  end

  // Per-core occupancy tracking
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      for (int k = 0; k < BLOCK_COUNT; k++) r_core[k] <= C_FREE;
    end else begin
      for (int k = 0; k < BLOCK_COUNT; k++) begin
        case (r_core[k])
          C_FREE:
            if (w_ld_issue && (w_iss_ptr == SEL_W'(k)))
              r_core[k] <= C_LOAD;
          C_LOAD:
            if (w_ld_fire && (r_ld_ptr == SEL_W'(k)))
              r_core[k] <= C_BUSY;
          C_BUSY:
            if (core_done[k]) r_core[k] <= C_READY;
          C_READY:
            if (w_st_fire && (r_st_ptr == SEL_W'(k)))
              r_core[k] <= C_FREE;
          default: r_core[k] <= C_FREE;
        endcase
      end
    end
  end

  // Job registers, counters, pointers and registered outputs
  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_mode       <= '0;
      r_total      <= '0;
      r_zero       <= 1'b0;
      r_ld_cnt     <= '0;
      r_st_cnt     <= '0;
      r_ld_ptr     <= '0;
      r_st_ptr     <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_ld_req     <= 1'b0;
      r_ld_idx     <= '0;
      r_ld_sel     <= '0;
      r_st_req     <= 1'b0;
      r_st_idx     <= '0;
      r_st_sel     <= '0;
      r_core_start <= '0;
      r_core_rel   <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_core_start <= '0;
      r_core_rel   <= '0;
      if (w_start_ok) begin
        r_mode   <= mode;
        r_total  <= task_total;
        r_zero   <= (task_total == '0);
        r_ld_cnt <= '0;
        r_st_cnt <= '0;
        r_ld_ptr <= '0;
        r_st_ptr <= '0;
      end
      if (w_ld_issue) begin
        r_ld_req <= 1'b1;
        r_ld_idx <= w_iss_idx;
        r_ld_sel <= w_iss_ptr;
      end else if (w_ld_fire) begin
        r_ld_req     <= 1'b0;
        r_core_start <= BLOCK_COUNT'(1) << r_ld_ptr;
        r_ld_cnt     <= r_ld_cnt + CNT_W'(1);
        r_ld_ptr     <= f_wrap(r_ld_ptr);
      end
      if (w_st_issue) begin
        r_st_req <= 1'b1;
        r_st_idx <= r_st_cnt;
        r_st_sel <= r_st_ptr;
      end else if (w_st_fire) begin
        r_st_req   <= 1'b0;
        r_core_rel <= BLOCK_COUNT'(1) << r_st_ptr;
        r_st_cnt   <= r_st_cnt + CNT_W'(1);
        r_st_ptr   <= f_wrap(r_st_ptr);
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign err          = r_err;
  assign ld_req       = r_ld_req;
  assign ld_idx       = r_ld_idx;
  assign ld_sel       = r_ld_sel;
  assign core_start   = r_core_start;
  assign core_mode    = r_mode;
  assign st_req       = r_st_req;
  assign st_idx       = r_st_idx;
  assign st_sel       = r_st_sel;
  assign core_release = r_core_rel;

endmodule

// File: tb/tb_paillier_task_scheduler.sv
// tb_paillier_task_scheduler: scoreboard bench with memory and core
// responders for paillier_task_scheduler.
module tb_paillier_task_scheduler;

  localparam int BC = 5;
  localparam int CW = 64;
  localparam int SW = 3;

  typedef struct {
    logic [63:0] idx;
    logic [2:0]  sel;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic [CW-1:0] task_total = '0;
  logic          busy, done, err;
  logic          ld_req, st_req;
  logic [CW-1:0] ld_idx, st_idx;
  logic [SW-1:0] ld_sel, st_sel;
  logic [BC-1:0] core_start, core_release;
  logic [1:0]    core_mode;
  logic          ld_ack = 1'b0;
  logic          st_ack_a = 1'b0;
  logic          st_ack_m = 1'b0;
  logic          st_ack;
  logic [BC-1:0] done_a = '0;
  logic [BC-1:0] man_done = '0;
  logic [BC-1:0] core_done;

  assign st_ack    = st_ack_a | st_ack_m;
  assign core_done = done_a | man_done;

  always #5 clk = ~clk;

  paillier_task_scheduler #(.BLOCK_COUNT(BC), .CNT_W(CW)) dut (
    .M_AXI_ACLK(clk),
    .M_AXI_ARESETN(rst_n),
    .start(start),
    .mode(mode),
    .task_total(task_total),
    .busy(busy),
    .done(done),
    .err(err),
    .ld_req(ld_req),
    .ld_idx(ld_idx),
    .ld_sel(ld_sel),
    .ld_ack(ld_ack),
    .core_start(core_start),
    .core_mode(core_mode),
    .core_done(core_done),
    .st_req(st_req),
    .st_idx(st_idx),
    .st_sel(st_sel),
    .st_ack(st_ack),
    .core_release(core_release)
  );

  int   n_vec = 0;
  int   n_bad = 0;
  int   done_cnt = 0;
  req_t exp_ld[$];
  req_t exp_st[$];
  int   exp_dn[$];

  int   ld_lat = 0;
  int   st_lat = 0;
  logic st_hold = 1'b0;
  int   core_lat[BC];
  int   cw[BC];
  int   ld_w = 0;
  int   st_w = 0;
  logic ld_prev = 1'b0;
  logic st_prev = 1'b0;
  logic [7:0] owed = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Monitor / scoreboard plus memory and core responders
  always @(negedge clk) begin
    req_t e;
    int   tok;
    if (!rst_n) begin
      owed = '0;
      ld_ack = 1'b0;
      st_ack_a = 1'b0;
      done_a = '0;
      ld_w = 0;
      st_w = 0;
      for (int k = 0; k < BC; k++) cw[k] = 0;
    end else begin
      if (ld_req && !ld_prev) begin
        if (exp_ld.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL ld_extra: idx %0d sel %0d, none expected",
                   ld_idx, ld_sel);
        end else begin
          e = exp_ld.pop_front();
          chk("ld_idx", ld_idx, e.idx);
          chk("ld_sel", 64'(ld_sel), 64'(e.sel));
        end
        chk("ld_core_free", 64'(owed[ld_sel]), 64'd0);
        owed[ld_sel] = 1'b1;
      end
      for (int k = 0; k < BC; k++)
        if (core_release[k]) owed[k] = 1'b0;
      if (st_req && !st_prev) begin
        if (exp_st.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL st_extra: idx %0d sel %0d, none expected",
                   st_idx, st_sel);
        end else begin
          e = exp_st.pop_front();
          chk("st_idx", st_idx, e.idx);
          chk("st_sel", 64'(st_sel), 64'(e.sel));
        end
      end
      if (done) begin
        if (exp_dn.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL done_extra: done pulse, none expected");
        end else begin
          tok = exp_dn.pop_front();
          if (tok > 0) chk("done_last_idx", st_idx, 64'(tok - 1));
          else         chk("done_zero_ldreq", 64'(ld_req), 64'd0);
        end
        done_cnt++;
      end
      if (ld_ack) ld_ack = 1'b0;
      else if (ld_req) begin
        if (ld_w >= ld_lat) begin ld_ack = 1'b1; ld_w = 0; end
        else ld_w++;
      end
      if (st_ack_a) st_ack_a = 1'b0;
      else if (st_req && !st_hold) begin
        if (st_w >= st_lat) begin st_ack_a = 1'b1; st_w = 0; end
        else st_w++;
      end
      for (int k = 0; k < BC; k++) begin
        done_a[k] = 1'b0;
        if (core_start[k]) cw[k] = core_lat[k];
        else if (cw[k] > 0) begin
          cw[k]--;
          if (cw[k] == 0) done_a[k] = 1'b1;
        end
      end
    end
    ld_prev = ld_req;
    st_prev = st_req;
  end

  task automatic push_job(input int n);
    for (int i = 0; i < n; i++) begin
      req_t e;
      e.idx = 64'(i);
      e.sel = 3'(i % BC);
      exp_ld.push_back(e);
      exp_st.push_back(e);
    end
    exp_dn.push_back(n);
  endtask

  task automatic set_lat(input int c);
    for (int k = 0; k < BC; k++) core_lat[k] = c;
  endtask

  task automatic do_start(input logic [1:0] m, input logic [63:0] n);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    task_total = n;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 64'(busy), 64'd1);
    chk("start_ldreq", 64'(ld_req), 64'(n != 0));
  endtask

  task automatic wait_done(input int budget);
    int c0 = done_cnt;
    int t = 0;
    while (done_cnt == c0 && t < budget) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done_cnt != c0), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_lat(3);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 64'({busy, done, err, ld_req, st_req}), 64'd0);
    chk("rst_pulse", 64'({core_start, core_release}), 64'd0);
    chk("rst_mode", 64'(core_mode), 64'd0);
    chk("rst_ld", ld_idx | 64'(ld_sel), 64'd0);
    chk("rst_st", st_idx | 64'(st_sel), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    ld_lat = 4;
    st_lat = 4;
    push_job(3);
    do_start(2'b10, 64'd3);
    wait_done(300);
    @(negedge clk);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_mode", 64'(core_mode), 64'd2);
    chk("t1_busy", 64'(busy), 64'd0);

    ld_lat = 0;
    st_lat = 0;
    set_lat(2);
    push_job(12);
    do_start(2'b01, 64'd12);
    repeat (4) @(negedge clk);
    start = 1'b1;
    mode = 2'b11;
    task_total = 64'd7;
    @(negedge clk);
    start = 1'b0;
    chk("t2_mode_kept", 64'(core_mode), 64'd1);
    wait_done(500);
    @(negedge clk);
    chk("t2_last_st", st_idx, 64'd11);
    chk("t2_busy", 64'(busy), 64'd0);

    set_lat(0);
    push_job(3);
    do_start(2'b00, 64'd3);
    repeat (12) @(negedge clk);
    chk("t3_no_st", 64'(st_req), 64'd0);
    man_done = 5'b00100;
    @(negedge clk);
    man_done = '0;
    @(negedge clk);
    chk("t3_st_after2", 64'(st_req), 64'd0);
    man_done = 5'b00010;
    @(negedge clk);
    man_done = '0;
    @(negedge clk);
    chk("t3_st_after1", 64'(st_req), 64'd0);
    man_done = 5'b00001;
    @(negedge clk);
    man_done = '0;
    chk("t3_st_after0", 64'(st_req), 64'd1);
    wait_done(100);
    @(negedge clk);
    chk("t3_err", 64'(err), 64'd0);

    set_lat(2);
    st_hold = 1'b1;
    push_job(6);
    do_start(2'b11, 64'd6);
    repeat (30) @(negedge clk);
    chk("t4_ld_blocked", 64'(ld_req), 64'd0);
    chk("t4_st_wait", 64'(st_req), 64'd1);
    chk("t4_st_idx", st_idx, 64'd0);
    st_ack_m = 1'b1;
    @(negedge clk);
    st_ack_m = 1'b0;
    chk("t4_release", 64'(core_release), 64'd1);
    chk("t4_ld_s1", 64'(ld_req), 64'd0);
    @(negedge clk);
    chk("t4_ld_s2", 64'(ld_req), 64'd1);
    chk("t4_ld_idx", ld_idx, 64'd5);
    chk("t4_ld_sel", 64'(ld_sel), 64'd0);
    st_hold = 1'b0;
    wait_done(200);
    @(negedge clk);

    exp_dn.push_back(0);
    do_start(2'b01, 64'd0);
    chk("t5_done_t1", 64'(done), 64'd0);
    @(negedge clk);
    chk("t5_done_t2", 64'(done), 64'd1);
    chk("t5_busy_t2", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);

    man_done = 5'b01000;
    @(negedge clk);
    man_done = '0;
    chk("t6_err_set", 64'(err), 64'd1);
    repeat (3) @(negedge clk);
    chk("t6_err_sticky", 64'(err), 64'd1);
    set_lat(0);
    begin
      req_t e;
      e.idx = 64'd0;
      e.sel = 3'd0;
      exp_ld.push_back(e);
    end
    do_start(2'b00, 64'd1);
    chk("t6_err_clr", 64'(err), 64'd0);
    repeat (4) @(negedge clk);
    chk("t6_busy_run", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_rst_ctrl", 64'({busy, done, err, ld_req, st_req}), 64'd0);
    chk("t6_rst_pulse", 64'({core_start, core_release}), 64'd0);
    chk("t6_rst_data", ld_idx | st_idx | 64'({ld_sel, st_sel, core_mode}),
        64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("q_ld_empty", 64'(exp_ld.size()), 64'd0);
    chk("q_st_empty", 64'(exp_st.size()), 64'd0);
    chk("q_dn_empty", 64'(exp_dn.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/paillier_task_scheduler.md
# paillier_task_scheduler

Sequences the Paillier compute array behind the AXI top. On a start command from the AXI-lite register file, it pulls `task_total` operand sets from memory through the AXI-full read engine. It dispatches each set to one of `BLOCK_COUNT` Paillier cores in round-robin order and retires results to memory through the AXI-full write engine, strictly in task order. It owns per-core occupancy tracking and end-of-job signalling.

## Interface

Parameters:
- `BLOCK_COUNT`, 5, number of Paillier cores scheduled.
- `CNT_W`, 64, task counter width (the `slv_reg3:slv_reg2` pair).
- `SEL_W`, `$clog2(BLOCK_COUNT)` (min 1), core select width; derived, not overridden.

Ports:
- `M_AXI_ACLK`, in, 1, single clock for the block.
- `M_AXI_ARESETN`, in, 1, reset; synchronous, active-low.
- `start`, in, 1, one-cycle job start pulse from the AXI-lite control register.
- `mode`, in, 2, operation: 00 encrypt, 01 decrypt, 10 homomorphic add, 11 scalar mul; latched on `start`.
- `task_total`, in, `CNT_W`, number of tasks in the job; latched on `start`.
- `busy`, out, 1, job in progress.
- `done`, out, 1, one-cycle pulse when the last result is stored.
- `err`, out, 1, sticky protocol error (spurious `core_done`); cleared by an accepted `start`.
- `ld_req`, out, 1, request operand load for task `ld_idx` into core `ld_sel`.
- `ld_idx`, out, `CNT_W`, task index to load.
- `ld_sel`, out, `SEL_W`, destination core.
- `ld_ack`, in, 1, operand load complete.
- `core_start`, out, `BLOCK_COUNT`, one-hot start pulse.
- `core_mode`, out, 2, latched `mode`.
- `core_done`, in, `BLOCK_COUNT`, per-core result-valid pulse; the core holds its result until released.
- `st_req`, out, 1, request result store of task `st_idx` from core `st_sel`.
- `st_idx`, out, `CNT_W`, task index to store.
- `st_sel`, out, `SEL_W`, source core.
- `st_ack`, in, 1, result store complete.
- `core_release`, out, `BLOCK_COUNT`, one-hot pulse freeing the core's result register.

## Operation

- Top FSM has three states: IDLE, RUN, FIN.
  - IDLE: on `start`, latch `mode` and `task_total`, clear counters and `err`, then go to RUN. If `task_total`==0, go to FIN instead.
  - RUN: exit to FIN when the store count equals `task_total`.
  - FIN: pulse `done`, return to IDLE.
  - `start` is ignored outside IDLE.
- Each core is in one of four states: FREE, LOAD, BUSY, READY.
- Task i is assigned to core i mod `BLOCK_COUNT`. Load and store pointers each wrap from `BLOCK_COUNT`-1 to 0, independent of index width.
- Load engine:
  - If `ld_cnt` < `task_total` and core[`ld_ptr`] is FREE, assert `ld_req` with `ld_idx`=`ld_cnt` and `ld_sel`=`ld_ptr`; the core moves to LOAD.
  - `ld_req`, `ld_idx` and `ld_sel` stay stable until `ld_ack`.
  - On `ld_ack`: core moves to BUSY, `core_start[ld_ptr]` pulses, `ld_cnt`++, `ld_ptr` advances.
- Core completion:
  - `core_done[k]` moves core k from BUSY to READY.
  - `core_done[k]` in any other state is ignored for state purposes and sets `err`.
  - Several `core_done` bits may assert in the same cycle.
- Store engine:
  - If core[`st_ptr`] is READY, assert `st_req` with `st_idx`=`st_cnt` and `st_sel`=`st_ptr`, held until `st_ack`.
  - On `st_ack`: `core_release[st_ptr]` pulses, core moves to FREE, `st_cnt`++, `st_ptr` advances.
  - Out-of-order completion is absorbed: a READY core waits for its turn.
- Load and store engines run concurrently.
- `ld_ack` without `ld_req`, or `st_ack` without `st_req`, is ignored.

## Timing

- All outputs are registered.
- Reset values: `busy`, `done`, `err`, `ld_req`, `st_req`, `core_start`, `core_release` = 0; `core_mode`, `ld_idx`, `ld_sel`, `st_idx`, `st_sel` = 0; every core FREE.
- `start` sampled at edge t: `busy`=1 and the first `ld_req`=1 in cycle t+1.
- `ld_ack` sampled at edge e:
  - `core_start` pulses and `ld_req` is 0 in cycle e+1.
  - The next `ld_req`, if eligible, asserts no earlier than cycle e+2.
- `core_done[k]` at edge d: `st_req` for core k asserts in cycle d+1 if k==`st_ptr`.
- `st_ack` at edge s:
  - `core_release` pulses and `st_req`=0 in cycle s+1.
  - The freed core is eligible for `ld_req` from cycle s+2.
- Last `st_ack` at edge s: FSM is in FIN during s+1 with `done`=1; `busy`=0 from s+2.
- `task_total`=0: `done` pulses at t+2, `busy` is high for cycle t+1 only, and no `ld_req` is issued.
- Reset asserted mid-job: the next edge forces all reset values, drops all requests mid-handshake, and issues no `done`.
- Counters compare at full `CNT_W` width; no overflow occurs for `task_total` ≤ 2^`CNT_W`-1.

## Test plan

- `BLOCK_COUNT`=5, `task_total`=3, acks after 4 cycles:
  - loads go to cores 0,1,2 with idx 0,1,2; stores in idx order 0,1,2.
  - Exactly one `done`; `err`=0.
- `task_total`=12, instant acks:
  - `ld_sel` sequence 0,1,2,3,4,0,1,…; task 5 is not loaded until core 0 is released.
  - 12 stores, final `st_idx`=11.
- Cores finish out of order (core 2, then 1, then 0) with `task_total`=3:
  - the first `st_req` occurs only after `core_done[0]`; stores run idx 0,1,2.
- Hold `st_ack` low with all 5 cores READY:
  - `ld_req` stays 0; releasing one store yields `ld_req` for task 5 on core 0 two cycles after `st_ack`.
- `task_total`=0: `done` at t+2 and no `ld_req`. A second `start` while `busy` is ignored, with counters unchanged.
- Pulse `core_done[3]` while core 3 is FREE: `err`=1 and stays set until the next `start`. Reset mid-run: all outputs 0 on the next cycle.
